// File: rtl/silu_lut_input_quantizer.sv
// Two-stage valid/ready stage that rounds signed fixed-point lanes to 3-bit
// SiLU LUT indices in [-4,3] and keeps a saturating count of clipped lanes.
module silu_lut_input_quantizer #(
    parameter int IN_WIDTH      = 8,
    parameter int IN_FRAC_WIDTH = 2,
    parameter int PARALLELISM   = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PARALLELISM*IN_WIDTH-1:0] data_in_0,
    input  logic                            data_in_0_valid,
    output logic                            data_in_0_ready,
    output logic [PARALLELISM*3-1:0]        data_out_0,
    output logic                            data_out_0_valid,
    input  logic                            data_out_0_ready,
    input  logic                            sat_count_clear,
    output logic [CNT_WIDTH-1:0]            sat_count
);
    localparam int RW    = IN_WIDTH + 1;
    localparam int PC_W  = $clog2(PARALLELISM + 1);
    localparam int SUM_W = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;
    // Half an LSB of the integer result; collapses to zero when there are no fraction bits.
    localparam logic signed [RW-1:0] RND   = RW'((32'sd1 << IN_FRAC_WIDTH) >>> 1);
    localparam logic signed [RW-1:0] R_MAX = RW'(32'sd3);
    localparam logic signed [RW-1:0] R_MIN = RW'(-32'sd4);

    function automatic logic signed [RW-1:0] round_lane(input logic signed [IN_WIDTH-1:0] x);
        logic signed [RW-1:0] ext;
        ext = {x[IN_WIDTH-1], x};
        return (ext + RND) >>> IN_FRAC_WIDTH;
    endfunction

    function automatic logic is_clipped(input logic signed [RW-1:0] r);
        return (r > R_MAX) || (r < R_MIN);
    endfunction

    function automatic logic [2:0] clamp_lane(input logic signed [RW-1:0] r);
        logic [2:0] c;
        if (r > R_MAX) begin
            c = 3'b011;
        end else if (r < R_MIN) begin
            c = 3'b100;
        end else begin
            c = r[2:0];
        end
        return c;
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [PARALLELISM-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    logic                          s1_valid_r;
    logic [PARALLELISM*RW-1:0]     s1_round_r;
    logic [PARALLELISM-1:0]        s1_sat_r;
    logic                          s2_valid_r;
    logic [PARALLELISM*3-1:0]      s2_idx_r;
    logic [PARALLELISM-1:0]        s2_sat_r;
    logic [CNT_WIDTH-1:0]          sat_count_r;

    logic                          s2_load_s;
    logic                          s1_load_s;
    logic                          out_fire_s;
    logic [PARALLELISM*RW-1:0]     round_s;
    logic [PARALLELISM-1:0]        sat_s;
    logic [PARALLELISM*3-1:0]      idx_s;
    logic [SUM_W-1:0]              sum_s;
    logic [CNT_WIDTH-1:0]          cnt_next_s;

    // Pipeline advance conditions.
    always_comb begin
        s2_load_s  = !s2_valid_r || data_out_0_ready;
        s1_load_s  = !s1_valid_r || s2_load_s;
        out_fire_s = s2_valid_r && data_out_0_ready;
    end

    // Per-lane rounding of the incoming beat and clamping of the stage-1 result.
    always_comb begin
        round_s = '0;
        sat_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            round_s[i*RW +: RW] = round_lane(data_in_0[i*IN_WIDTH +: IN_WIDTH]);
            sat_s[i]            = is_clipped(round_lane(data_in_0[i*IN_WIDTH +: IN_WIDTH]));
            idx_s[i*3 +: 3]     = clamp_lane(s1_round_r[i*RW +: RW]);
        end
    end

    // Saturating next value of the clipped-lane counter.
    always_comb begin
        sum_s = SUM_W'(sat_count_r) + SUM_W'(popcount(s2_sat_r));
        if (sum_s > SUM_W'({CNT_WIDTH{1'b1}})) begin
            cnt_next_s = '1;
        end else begin
            cnt_next_s = sum_s[CNT_WIDTH-1:0];
        end
    end

    // Stage 1 (round) and stage 2 (saturate) registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_round_r <= '0;
            s1_sat_r   <= '0;
            s2_valid_r <= 1'b0;
            s2_idx_r   <= '0;
            s2_sat_r   <= '0;
        end else begin
            if (s1_load_s) begin
                s1_valid_r <= data_in_0_valid;
                if (data_in_0_valid) begin
                    s1_round_r <= round_s;
                    s1_sat_r   <= sat_s;
                end
            end
            if (s2_load_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_idx_r <= idx_s;
                    s2_sat_r <= s1_sat_r;
                end
            end
        end
    end

    // Clipped-lane counter; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_count_r <= '0;
        end else if (sat_count_clear) begin
            sat_count_r <= '0;
        end else if (out_fire_s) begin
            sat_count_r <= cnt_next_s;
        end
    end

    assign data_in_0_ready  = s1_load_s;
    assign data_out_0       = s2_idx_r;
    assign data_out_0_valid = s2_valid_r;
    assign sat_count        = sat_count_r;

endmodule

// File: tb/tb_silu_lut_input_quantizer.sv
// Scoreboard bench: three instances (default, 2-bit counter, no fraction bits)
// share clock, reset and downstream ready; each has its own input stream.
module tb_silu_lut_input_quantizer;
    typedef struct {
        logic [11:0] d;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        out_ready;
    logic [31:0] m_din, c_din, f_din;
    logic        m_dv, c_dv, f_dv;
    logic        m_rdy, c_rdy, f_rdy;
    logic [11:0] m_dout, c_dout, f_dout;
    logic        m_ov, c_ov, f_ov;
    logic        m_clr, c_clr, f_clr;
    logic [15:0] m_cnt, f_cnt;
    logic [1:0]  c_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t m_q[$];
    exp_t c_q[$];
    exp_t f_q[$];

    logic [31:0] vin [5];
    logic [11:0] vout [5];

    silu_lut_input_quantizer #(.IN_WIDTH(8), .IN_FRAC_WIDTH(2), .PARALLELISM(4), .CNT_WIDTH(16)) dut_main (
        .clk(clk), .rst(rst), .data_in_0(m_din), .data_in_0_valid(m_dv), .data_in_0_ready(m_rdy),
        .data_out_0(m_dout), .data_out_0_valid(m_ov), .data_out_0_ready(out_ready),
        .sat_count_clear(m_clr), .sat_count(m_cnt));

    silu_lut_input_quantizer #(.IN_WIDTH(8), .IN_FRAC_WIDTH(2), .PARALLELISM(4), .CNT_WIDTH(2)) dut_cnt2 (
        .clk(clk), .rst(rst), .data_in_0(c_din), .data_in_0_valid(c_dv), .data_in_0_ready(c_rdy),
        .data_out_0(c_dout), .data_out_0_valid(c_ov), .data_out_0_ready(out_ready),
        .sat_count_clear(c_clr), .sat_count(c_cnt));

    silu_lut_input_quantizer #(.IN_WIDTH(8), .IN_FRAC_WIDTH(0), .PARALLELISM(4), .CNT_WIDTH(16)) dut_frac0 (
        .clk(clk), .rst(rst), .data_in_0(f_din), .data_in_0_valid(f_dv), .data_in_0_ready(f_rdy),
        .data_out_0(f_dout), .data_out_0_valid(f_ov), .data_out_0_ready(out_ready),
        .sat_count_clear(f_clr), .sat_count(f_cnt));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [11:0] px(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] c, input logic [2:0] d);
        return {d, c, b, a};
    endfunction

    // Monitor: pops the expected beat on every output transfer of each instance.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && out_ready && m_ov) begin
            checks++;
            if (m_q.size() == 0) begin
                errors++;
                $display("FAIL main_unexpected_output got=%h want=none", m_dout);
            end else begin
                e = m_q.pop_front();
                if (m_dout !== e.d || (e.cyc >= 0 && cyc != e.cyc)) begin
                    errors++;
                    $display("FAIL main_output got=%h@%0d want=%h@%0d", m_dout, cyc, e.d, e.cyc);
                end
            end
        end
        if (rst && out_ready && c_ov) begin
            checks++;
            if (c_q.size() == 0) begin
                errors++;
                $display("FAIL cnt2_unexpected_output got=%h want=none", c_dout);
            end else begin
                e = c_q.pop_front();
                if (c_dout !== e.d || (e.cyc >= 0 && cyc != e.cyc)) begin
                    errors++;
                    $display("FAIL cnt2_output got=%h@%0d want=%h@%0d", c_dout, cyc, e.d, e.cyc);
                end
            end
        end
        if (rst && out_ready && f_ov) begin
            checks++;
            if (f_q.size() == 0) begin
                errors++;
                $display("FAIL frac0_unexpected_output got=%h want=none", f_dout);
            end else begin
                e = f_q.pop_front();
                if (f_dout !== e.d || (e.cyc >= 0 && cyc != e.cyc)) begin
                    errors++;
                    $display("FAIL frac0_output got=%h@%0d want=%h@%0d", f_dout, cyc, e.d, e.cyc);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Offer one beat to instance k; queue its expected output once it is accepted.
    task automatic send(input int k, input logic [31:0] d, input logic [11:0] e, input bit lat);
        exp_t x;
        bit   ok;
        ok = 1'b0;
        case (k)
            0:       begin m_din = d; m_dv = 1'b1; end
            1:       begin c_din = d; c_dv = 1'b1; end
            default: begin f_din = d; f_dv = 1'b1; end
        endcase
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            case (k)
                0:       ok = m_rdy;
                1:       ok = c_rdy;
                default: ok = f_rdy;
            endcase
        end
        x.d   = e;
        x.cyc = lat ? cyc + 2 : -1;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout inst=%0d got ready=0 want ready=1", k);
        end else begin
            case (k)
                0:       m_q.push_back(x);
                1:       c_q.push_back(x);
                default: f_q.push_back(x);
            endcase
        end
        @(posedge clk);
        #1;
        case (k)
            0:       m_dv = 1'b0;
            1:       c_dv = 1'b0;
            default: f_dv = 1'b0;
        endcase
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_q.size() + c_q.size() + f_q.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d want pending=0", m_q.size() + c_q.size() + f_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; out_ready = 1'b1;
        m_din = '0; c_din = '0; f_din = '0;
        m_dv = 1'b0; c_dv = 1'b0; f_dv = 1'b0;
        m_clr = 1'b0; c_clr = 1'b0; f_clr = 1'b0;
        vin[0] = pk(6, 5, -6, 0);        vout[0] = px(3'b010, 3'b001, 3'b111, 3'b000);
        vin[1] = pk(127, -128, 12, -17); vout[1] = px(3'b011, 3'b100, 3'b011, 3'b100);
        vin[2] = pk(2, 1, -2, -3);       vout[2] = px(3'b001, 3'b000, 3'b000, 3'b111);
        vin[3] = pk(14, 13, -14, -18);   vout[3] = px(3'b011, 3'b011, 3'b101, 3'b100);
        vin[4] = pk(-19, 10, -10, 100);  vout[4] = px(3'b100, 3'b011, 3'b110, 3'b011);

        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(m_ov), 32'd0);
        check("reset_data_out", 32'(m_dout), 32'd0);
        check("reset_sat_count", 32'(m_cnt), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(m_rdy), 32'd1);

        // Single beats; only 127 and -128 clip (-17 rounds to exactly -4).
        send(0, vin[0], vout[0], 1'b1);
        drain();
        check("t1_sat_count", 32'(m_cnt), 32'd0);
        send(0, vin[1], vout[1], 1'b1);
        drain();
        check("t2_sat_count", 32'(m_cnt), 32'd2);

        // Back-to-back stream; 4 passes of 5 clips each.
        for (int i = 0; i < 20; i++) send(0, vin[i % 5], vout[i % 5], 1'b1);
        drain();
        check("t3_sat_count", 32'(m_cnt), 32'd22);

        // Downstream stall with input held valid.
        out_ready = 1'b0;
        fork
            begin
                send(0, vin[1], vout[1], 1'b0);
                send(0, vin[3], vout[3], 1'b0);
                send(0, vin[4], vout[4], 1'b0);
                send(0, vin[0], vout[0], 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("t4_in_ready_low", 32'(m_rdy), 32'd0);
                    check("t4_out_valid", 32'(m_ov), 32'd1);
                    check("t4_out_held", 32'(m_dout), 32'(vout[1]));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("t4_sat_count", 32'(m_cnt), 32'd27);

        // Clear in the same cycle as a clipping transfer.
        out_ready = 1'b0;
        send(0, vin[4], vout[4], 1'b0);
        @(posedge clk);
        #1;
        check("t5_count_before_transfer", 32'(m_cnt), 32'd27);
        check("t5_out_valid_held", 32'(m_ov), 32'd1);
        m_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        m_clr = 1'b0;
        check("t5_clear_wins", 32'(m_cnt), 32'd0);
        send(0, vin[3], vout[3], 1'b1);
        drain();
        check("t5_count_after_clear", 32'(m_cnt), 32'd1);

        // Reset with both stages full in the default and no-fraction instances.
        out_ready = 1'b0;
        send(0, vin[2], vout[2], 1'b0);
        send(0, vin[0], vout[0], 1'b0);
        send(2, pk(2, 9, -5, -4), px(3'b010, 3'b011, 3'b100, 3'b100), 1'b0);
        send(2, pk(-1, 3, 4, -128), px(3'b111, 3'b011, 3'b011, 3'b100), 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_out_valid", 32'(m_ov), 32'd0);
        check("t6_rst_data_out", 32'(m_dout), 32'd0);
        check("t6_rst_sat_count", 32'(m_cnt), 32'd0);
        check("t6_rst_frac0_valid", 32'(f_ov), 32'd0);
        m_q.delete();
        f_q.delete();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t6_ready_after_release", 32'(m_rdy), 32'd1);
        send(0, vin[3], vout[3], 1'b1);
        send(2, pk(2, 9, 0, 1), px(3'b010, 3'b011, 3'b000, 3'b001), 1'b1);
        drain();
        check("t6_main_sat_count", 32'(m_cnt), 32'd1);
        check("t6_frac0_sat_count", 32'(f_cnt), 32'd1);

        // Two-bit counter: 2 clips, then 3 more must stick at 3 rather than wrap.
        send(1, vin[1], vout[1], 1'b1);
        drain();
        check("cnt2_count_two", 32'(c_cnt), 32'd2);
        send(1, vin[3], vout[3], 1'b1);
        send(1, vin[4], vout[4], 1'b1);
        drain();
        check("cnt2_saturates", 32'(c_cnt), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
